// File: rtl/sr04_pkg.sv
// sr04_pkg: shared HC-SR04 protocol definitions (FSM states, default timing
// constants, echo length clamp) used by both the emulator and the controller.
package sr04_pkg;

    // Sensor-side protocol phases.
    typedef enum logic [2:0] {
        IDLE,
        TRIG_HIGH,
        BURST,
        ECHO,
        HOLDOFF
    } sr04_state_e;

    // Default protocol timing, in clk cycles.
    localparam int DEF_MIN_TRIG_CYCLES = 10;
    localparam int DEF_BURST_CYCLES    = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 600;
    localparam int DEF_HOLDOFF_CYCLES  = 20;

    localparam int LEN_W  = 16;
    localparam int MISS_W = 8;

    // Zero means "no obstacle" and over-range values are clamped, both of
    // which map to the timeout echo width.
    function automatic logic [LEN_W-1:0] clamp_echo_len(
        input logic [LEN_W-1:0] i_len,
        input logic [LEN_W-1:0] i_timeout
    );
        if (i_len == '0 || i_len > i_timeout) begin
            return i_timeout;
        end
        return i_len;
    endfunction

endpackage

// File: rtl/sr04_echo_emulator_if.sv
// sr04_echo_emulator_if: trigger/echo bundle between an SR04 controller
// (master) and the sensor side (slave).
//   trigger_in  master->slave  trigger line (asynchronous to clk)
//   echo_len    master->slave  programmed echo width, 0 = no obstacle
//   echo_out    slave->master  echo line
//   busy        slave->master  sensor is bursting, echoing or recovering
//   trig_err    slave->master  one-cycle pulse on a too-short trigger
//   missed_cnt  slave->master  saturating count of ignored triggers
interface sr04_echo_emulator_if;
    import sr04_pkg::*;

    logic              trigger_in;
    logic [LEN_W-1:0]  echo_len;
    logic              echo_out;
    logic              busy;
    logic              trig_err;
    logic [MISS_W-1:0] missed_cnt;

    modport master (
        output trigger_in,
        output echo_len,
        input  echo_out,
        input  busy,
        input  trig_err,
        input  missed_cnt
    );

    modport slave (
        input  trigger_in,
        input  echo_len,
        output echo_out,
        output busy,
        output trig_err,
        output missed_cnt
    );

endinterface

// File: rtl/sr04_sync_edge.sv
// sr04_sync_edge: 2-flop synchronizer with registered rise/fall pulses.
// Ports: clk, reset (async, active-high), i_d (async input),
//        o_sync (synchronized level), o_rise / o_fall (one-cycle pulses,
//        aligned with the cycle o_sync takes its new value).
module sr04_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_rise;
    logic r_fall;

    // Edges are decoded from the meta/sync pair so the pulse lands in the
    // same cycle as the new synchronized level: two cycles of latency total.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
            r_rise <= r_meta & ~r_sync;
            r_fall <= ~r_meta & r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/sr04_echo_emulator.sv
// sr04_echo_emulator: sensor side of the HC-SR04 trigger/echo protocol.
// Validates the trigger width, waits a burst delay, then drives echo high
// for the programmed number of cycles, followed by a recovery holdoff.
// Ports: clk, reset (async, active-high), bus (slave modport of
//        sr04_echo_emulator_if: trigger_in, echo_len in; echo_out, busy,
//        trig_err, missed_cnt out).
module sr04_echo_emulator
    import sr04_pkg::*;
#(
    parameter int MIN_TRIG_CYCLES = DEF_MIN_TRIG_CYCLES,
    parameter int BURST_CYCLES    = DEF_BURST_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    sr04_echo_emulator_if.slave  bus
);

    localparam logic [LEN_W-1:0] C_MIN_TRIG  = LEN_W'(MIN_TRIG_CYCLES);
    localparam logic [LEN_W-1:0] C_TIMEOUT   = LEN_W'(TIMEOUT_CYCLES);
    localparam logic [LEN_W-1:0] C_BURST_LD  = LEN_W'(BURST_CYCLES - 1);
    localparam logic [LEN_W-1:0] C_HOLD_LD   = LEN_W'(HOLDOFF_CYCLES - 1);
    localparam logic [LEN_W-1:0] C_WIDTH_MAX = '1;
    localparam logic [MISS_W-1:0] C_MISS_MAX = '1;

    logic w_trig_sync;
    logic w_trig_rise;
    logic w_trig_fall;
    logic w_missed_rise;

    sr04_state_e       r_state;
    logic [LEN_W-1:0]  r_width;
    logic [LEN_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_len;
    logic              r_echo;
    logic              r_busy;
    logic              r_trig_err;
    logic [MISS_W-1:0] r_missed;

    sr04_sync_edge u_trig_sync (
        .clk    (clk),
        .reset  (reset),
        .i_d    (bus.trigger_in),
        .o_sync (w_trig_sync),
        .o_rise (w_trig_rise),
        .o_fall (w_trig_fall)
    );

    // Any rise outside IDLE/TRIG_HIGH is dropped, including one landing on
    // the final HOLDOFF cycle.
    assign w_missed_rise = w_trig_rise &&
                           (r_state == BURST ||
                            r_state == ECHO  ||
                            r_state == HOLDOFF);

    // r_cnt is a shared down-counter: loaded with (phase length - 1) on
    // phase entry, phase ends on the cycle it reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_width    <= '0;
            r_cnt      <= '0;
            r_len      <= '0;
            r_echo     <= 1'b0;
            r_busy     <= 1'b0;
            r_trig_err <= 1'b0;
            r_missed   <= '0;
        end else begin
            r_trig_err <= 1'b0;

            if (w_missed_rise && r_missed != C_MISS_MAX) begin
                r_missed <= r_missed + 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (w_trig_rise) begin
                        r_width <= LEN_W'(1);
                        r_state <= TRIG_HIGH;
                    end
                end

                TRIG_HIGH: begin
                    if (w_trig_fall) begin
                        if (r_width < C_MIN_TRIG) begin
                            r_trig_err <= 1'b1;
                            r_state    <= IDLE;
                        end else begin
                            // echo_len is only looked at here
                            r_len   <= clamp_echo_len(bus.echo_len,
                                                      C_TIMEOUT);
                            r_cnt   <= C_BURST_LD;
                            r_busy  <= 1'b1;
                            r_state <= BURST;
                        end
                    end else if (w_trig_sync &&
                                 r_width != C_WIDTH_MAX) begin
                        r_width <= r_width + 1'b1;
                    end
                end

                BURST: begin
                    if (r_cnt == '0) begin
                        // r_len is never 0 after clamping
                        r_cnt   <= r_len - 1'b1;
                        r_echo  <= 1'b1;
                        r_state <= ECHO;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ECHO: begin
                    if (r_cnt == '0) begin
                        r_cnt   <= C_HOLD_LD;
                        r_echo  <= 1'b0;
                        r_state <= HOLDOFF;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                HOLDOFF: begin
                    if (r_cnt == '0) begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                default: begin
                    r_echo  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.echo_out   = r_echo;
    assign bus.busy       = r_busy;
    assign bus.trig_err   = r_trig_err;
    assign bus.missed_cnt = r_missed;

endmodule

// File: tb/tb_sr04_echo_emulator.sv
// tb_sr04_echo_emulator: directed vector table, multi-cycle sequences and a
// randomized run checked against an interval-based model of the protocol.
module tb_sr04_echo_emulator;

    localparam int MIN_TRIG = 10;
    localparam int BURST    = 16;
    localparam int TIMEOUT  = 600;
    localparam int HOLD     = 20;
    localparam int SYNC_LAT = 2;
    localparam int LIM      = 700;
    localparam int H        = 6000;
    // offsets from the cycle trigger_in is dropped
    localparam int K_ERR    = SYNC_LAT + 1;
    localparam int K_BUSY   = SYNC_LAT + 1;
    localparam int K_ECHO   = SYNC_LAT + 1 + BURST;

    typedef struct {
        int w;
        int len;
        int exp_err;
        int exp_len;
    } vec_t;

    typedef struct {
        int echo_first;
        int echo_cnt;
        int echo_rises;
        int busy_first;
        int busy_last;
        int err_first;
        int err_cnt;
    } meas_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    bit          tr[H];
    logic [15:0] lv[H];
    bit          e_echo[H];
    bit          e_busy[H];
    bit          e_err[H];
    int          e_miss[H];
    int          inc_at[H];

    sr04_echo_emulator_if bus ();

    sr04_echo_emulator dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    function automatic int clampv(input int v);
        return (v == 0 || v > TIMEOUT) ? TIMEOUT : v;
    endfunction

    // One trigger of width w, then LIM cycles of observation. Optional
    // echo_len change at cycle chg_k and a train of extra trigger pulses.
    task automatic measure(input int w, input int len,
                           input int chg_k, input int chg_len,
                           input int nmiss, input int mstart,
                           input int mhigh, input int mper,
                           output meas_t m);
        bit prev_e;
        m.echo_first = -1;
        m.echo_cnt   = 0;
        m.echo_rises = 0;
        m.busy_first = -1;
        m.busy_last  = -1;
        m.err_first  = -1;
        m.err_cnt    = 0;
        @(negedge clk);
        bus.echo_len   = 16'(len);
        bus.trigger_in = 1'b1;
        repeat (w) @(negedge clk);
        bus.trigger_in = 1'b0;
        prev_e = 1'b0;
        for (int k = 0; k < LIM; k++) begin
            if (k == chg_k) bus.echo_len = 16'(chg_len);
            if (nmiss > 0 && k >= mstart && k < mstart + nmiss * mper)
                bus.trigger_in = ((k - mstart) % mper) < mhigh;
            else
                bus.trigger_in = 1'b0;
            if (bus.echo_out) begin
                if (m.echo_first < 0) m.echo_first = k;
                m.echo_cnt++;
                if (!prev_e) m.echo_rises++;
            end
            prev_e = bus.echo_out;
            if (bus.busy) begin
                if (m.busy_first < 0) m.busy_first = k;
                m.busy_last = k;
            end
            if (bus.trig_err) begin
                if (m.err_first < 0) m.err_first = k;
                m.err_cnt++;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_meas(input string nm, input meas_t m,
                              input int exp_err, input int exp_len);
        if (exp_err != 0) begin
            check({nm, ".err_cnt"}, m.err_cnt, 1);
            check({nm, ".err_at"}, m.err_first, K_ERR);
            check({nm, ".echo_cnt"}, m.echo_cnt, 0);
            check({nm, ".busy_at"}, m.busy_first, -1);
        end else begin
            check({nm, ".err_cnt"}, m.err_cnt, 0);
            check({nm, ".echo_cnt"}, m.echo_cnt, exp_len);
            check({nm, ".echo_rises"}, m.echo_rises, 1);
            check({nm, ".echo_at"}, m.echo_first, K_ECHO);
            check({nm, ".busy_at"}, m.busy_first, K_BUSY);
            check({nm, ".busy_last"}, m.busy_last,
                  K_ECHO + exp_len + HOLD - 1);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.trigger_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        vec_t  vt[10];
        meas_t m;
        int    cnt_e;
        int    cnt_b;
        int    t;
        int    t_free;
        int    mm;

        vt[0] = '{12, 100, 0, 100};
        vt[1] = '{5, 100, 1, 0};
        vt[2] = '{9, 50, 1, 0};
        vt[3] = '{10, 50, 0, 50};
        vt[4] = '{12, 0, 0, 600};
        vt[5] = '{12, 5000, 0, 600};
        vt[6] = '{12, 600, 0, 600};
        vt[7] = '{12, 601, 0, 600};
        vt[8] = '{12, 1, 0, 1};
        vt[9] = '{1, 30, 1, 0};

        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus.trigger_in = 1'b0;
        bus.echo_len = 16'd0;
        repeat (3) @(negedge clk);
        check("rst.echo", int'(bus.echo_out), 0);
        check("rst.busy", int'(bus.busy), 0);
        check("rst.err", int'(bus.trig_err), 0);
        check("rst.missed", int'(bus.missed_cnt), 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            measure(vt[i].w, vt[i].len, -1, 0, 0, 0, 1, 1, m);
            check_meas($sformatf("vec%0d", i), m,
                       vt[i].exp_err, vt[i].exp_len);
        end
        check("vec.missed", int'(bus.missed_cnt), 0);

        // three triggers during ECHO
        measure(12, 200, -1, 0, 3, 40, 3, 10, m);
        check_meas("retrig3", m, 0, 200);
        check("retrig3.missed", int'(bus.missed_cnt), 3);

        // 300 more ignored triggers saturate the counter
        measure(12, 600, -1, 0, 300, 4, 1, 2, m);
        check_meas("retrig300", m, 0, 600);
        check("retrig300.missed", int'(bus.missed_cnt), 255);

        // echo_len change during BURST must not affect the echo
        measure(12, 100, 8, 40, 0, 0, 1, 1, m);
        check_meas("lenchg", m, 0, 100);
        measure(12, 40, -1, 0, 0, 0, 1, 1, m);
        check_meas("lenchg.next", m, 0, 40);

        // reset in the middle of ECHO
        @(negedge clk);
        bus.echo_len = 16'd300;
        bus.trigger_in = 1'b1;
        repeat (12) @(negedge clk);
        bus.trigger_in = 1'b0;
        repeat (K_ECHO + 50) @(negedge clk);
        check("rstmid.echo_before", int'(bus.echo_out), 1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid.echo_async", int'(bus.echo_out), 0);
        check("rstmid.busy", int'(bus.busy), 0);
        check("rstmid.missed", int'(bus.missed_cnt), 0);
        @(negedge clk);
        reset = 1'b0;
        cnt_e = 0;
        cnt_b = 0;
        for (int k = 0; k < LIM; k++) begin
            if (bus.echo_out) cnt_e++;
            if (bus.busy) cnt_b++;
            @(negedge clk);
        end
        check("rstmid.echo_after", cnt_e, 0);
        check("rstmid.busy_after", cnt_b, 0);
        measure(12, 77, -1, 0, 0, 0, 1, 1, m);
        check_meas("rstmid.new", m, 0, 77);

        // randomized run: stimulus tables, then model from pulse intervals
        for (int c = 0; c < H; c++) begin
            int sel;
            tr[c] = 1'b0;
            e_echo[c] = 1'b0;
            e_busy[c] = 1'b0;
            e_err[c] = 1'b0;
            inc_at[c] = 0;
            sel = $urandom_range(0, 9);
            case (sel)
                0: lv[c] = 16'd0;
                1: lv[c] = 16'($urandom_range(601, 65535));
                2: lv[c] = 16'd600;
                3: lv[c] = 16'd1;
                default: lv[c] = 16'($urandom_range(1, 120));
            endcase
        end
        t = 5;
        t_free = 0;
        while (t < H - 800) begin
            int w;
            int a;
            int b;
            int r;
            int f;
            int len;
            w = $urandom_range(1, 16);
            a = t;
            b = t + w;
            for (int i = a; i < b; i++) tr[i] = 1'b1;
            r = a + SYNC_LAT;
            f = b + SYNC_LAT;
            if (r < t_free) begin
                inc_at[r + 1]++;
            end else if (w < MIN_TRIG) begin
                e_err[f + 1] = 1'b1;
                t_free = f + 1;
            end else begin
                len = clampv(int'(lv[f]));
                for (int i = f + 1; i < f + 1 + BURST + len + HOLD; i++)
                    e_busy[i] = 1'b1;
                for (int i = f + 1 + BURST; i < f + 1 + BURST + len; i++)
                    e_echo[i] = 1'b1;
                t_free = f + 1 + BURST + len + HOLD;
            end
            t = b + $urandom_range(1, 60);
        end
        mm = 0;
        for (int c = 0; c < H; c++) begin
            mm = mm + inc_at[c];
            if (mm > 255) mm = 255;
            e_miss[c] = mm;
        end

        do_reset();
        for (int c = 0; c < H; c++) begin
            bus.trigger_in = tr[c];
            bus.echo_len = lv[c];
            check($sformatf("rnd.echo@%0d", c),
                  int'(bus.echo_out), int'(e_echo[c]));
            check($sformatf("rnd.busy@%0d", c),
                  int'(bus.busy), int'(e_busy[c]));
            check($sformatf("rnd.err@%0d", c),
                  int'(bus.trig_err), int'(e_err[c]));
            check($sformatf("rnd.missed@%0d", c),
                  int'(bus.missed_cnt), e_miss[c]);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sr04_echo_emulator.md
# sr04_echo_emulator

Synthesizable model of the sensor side of the HC-SR04 trigger/echo protocol: it watches the trigger line, validates the trigger pulse width, waits a fixed burst delay, then drives echo high for a programmed number of clock cycles. It sits on the board or in the bench opposite the SR04 controller. This lets the controller be closed-loop tested in hardware without a physical sensor.

## Interface
- MIN_TRIG_CYCLES, 10: minimum trigger high width, in cycles, accepted as a valid trigger.
- BURST_CYCLES, 16: echo-low delay after trigger falls, modelling the 8-cycle ultrasonic burst.
- TIMEOUT_CYCLES, 600: echo width used for "no obstacle"; also the clamp for `echo_len`.
- HOLDOFF_CYCLES, 20: recovery time after echo falls, during which triggers are ignored.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high.
- trigger_in  input  1  trigger from the controller; asynchronous to clk.
- echo_len  input  16  echo high width in cycles; 0 means "no obstacle".
- echo_out  output  1  echo line to the controller.
- busy  output  1  high in any state other than IDLE or TRIG_HIGH.
- trig_err  output  1  one-cycle pulse when a trigger shorter than MIN_TRIG_CYCLES ends.
- missed_cnt  output  8  saturating count of trigger rising edges ignored while busy.

## Operation
- Input conditioning: `trigger_in` passes through a 2-flop synchronizer, then a rise/fall detector on the synchronized value. The FSM uses only the synchronized signal.
- IDLE: on a synchronized rise, go to TRIG_HIGH with the width counter cleared to 1.
- TRIG_HIGH: increment the width counter each cycle while the trigger stays high. The counter is 16 bits and saturates.
- Fall in TRIG_HIGH with width < MIN_TRIG_CYCLES: pulse `trig_err` for one cycle and return to IDLE.
- Fall in TRIG_HIGH with width ≥ MIN_TRIG_CYCLES: latch the echo length, then go to BURST.
  - If `echo_len` == 0 or `echo_len` > TIMEOUT_CYCLES, latch TIMEOUT_CYCLES.
  - Otherwise latch `echo_len`.
- BURST: `echo_out` low for exactly BURST_CYCLES cycles, then go to ECHO.
- ECHO: `echo_out` high for exactly the latched length, then go to HOLDOFF.
- HOLDOFF: `echo_out` low for HOLDOFF_CYCLES cycles, then go to IDLE.
- A synchronized rise seen in BURST, ECHO or HOLDOFF is ignored. It increments `missed_cnt`, which saturates at 255.
- `echo_len` is sampled only at the fall cycle. Later changes do not affect an echo already in progress.
- Reset values: `echo_out`=0, `busy`=0, `trig_err`=0, `missed_cnt`=0, state IDLE, all counters 0.
- Reset mid-operation forces `echo_out` low asynchronously. No echo resumes after reset releases.

## Timing
- Trigger edges reach the FSM 2 cycles after they appear on `trigger_in`. Measured width equals the input width ±1 cycle.
- Suppose the synchronized fall is detected in cycle F. Then:
  - `busy` rises at F+1.
  - `echo_out` rises at F+1+BURST_CYCLES.
  - `echo_out` falls at F+1+BURST_CYCLES+len.
  - `busy` falls HOLDOFF_CYCLES after `echo_out` falls.
- `trig_err` is asserted in cycle F+1 for exactly one cycle.
- Echo width on the pin is exact: the controller must measure `len` cycles, with no ±1 slop.
- A rise and a fall in the same synchronized cycle are impossible by construction. A trigger still high when HOLDOFF ends is not a new trigger; only a fresh rise in IDLE starts one.
- The last HOLDOFF cycle transitions to IDLE. A rise detected in that same cycle is counted as missed.

## Structure
- Shared package `sr04_pkg` holds:
  - the FSM state enum (IDLE, TRIG_HIGH, BURST, ECHO, HOLDOFF);
  - default protocol constants (trigger width, burst, timeout), shared with the controller so both ends agree.
- Sub-module `sr04_sync_edge` holds the 2-flop synchronizer and the registered rise/fall pulse outputs; it is reused for the controller's echo input.
- Down-counters are preferred over up-counters with compares for the BURST, ECHO and HOLDOFF phases.

## Test plan
- Nominal: `echo_len`=100, 12-cycle trigger → `echo_out` low for 16 cycles after the detected fall, then high exactly 100 cycles; `busy` drops 20 cycles later.
- Short trigger: 5-cycle pulse → `trig_err` one-cycle pulse, `echo_out` never rises, `busy` stays 0.
- No obstacle / clamp: `echo_len`=0 → echo 600 cycles; `echo_len`=5000 → echo 600 cycles.
- Retrigger: three triggers issued during ECHO → `missed_cnt`=3 and the echo width is unchanged; 300 ignored triggers → `missed_cnt`=255.
- `echo_len` changed from 100 to 40 mid-BURST → echo is still 100 cycles; the next trigger yields 40.
- Reset asserted mid-ECHO → `echo_out` goes to 0 without waiting for a clock edge; after release, no echo until a new valid trigger arrives.
